// File: rtl/execute_stage.sv
// Execute stage: operand select, ALU, address/branch-target adder and destination
// register decode, captured into output registers on each enable_execute strobe.
module execute_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_execute,
    input  logic [5:0]  E_Control,
    input  logic [47:0] D_Data,
    input  logic [15:0] npc_in,
    input  logic [1:0]  W_Control_in,
    input  logic        Mem_Control_in,
    output logic [15:0] aluout,
    output logic [15:0] pcout,
    output logic [15:0] M_Data,
    output logic [2:0]  dr,
    output logic [1:0]  W_Control_out,
    output logic        Mem_Control_out,
    output logic [15:0] npc_out,
    output logic        exec_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [15:0] ir;
    logic [15:0] vsr1;
    logic [15:0] vsr2;
    logic [15:0] op2;
    logic [15:0] alu_next;
    logic [15:0] offset;
    logic [15:0] base;
    logic [15:0] pc_next;
    logic [2:0]  dr_next;

    assign ir   = D_Data[47:32];
    assign vsr1 = D_Data[31:16];
    assign vsr2 = D_Data[15:0];

    always_comb begin
        op2 = E_Control[3] ? {{11{ir[4]}}, ir[4:0]} : vsr2;

        alu_next = 16'h0000;
        case (E_Control[5:4])
            2'b00:   alu_next = vsr1 + op2;
            2'b01:   alu_next = vsr1 & op2;
            2'b10:   alu_next = ~vsr1;
            default: alu_next = 16'h0000;
        endcase

        offset = 16'h0000;
        case (E_Control[2:1])
            2'b00:   offset = {{5{ir[10]}}, ir[10:0]};
            2'b01:   offset = {{7{ir[8]}}, ir[8:0]};
            2'b10:   offset = {{10{ir[5]}}, ir[5:0]};
            default: offset = 16'h0000;
        endcase

        base    = E_Control[0] ? npc_in : vsr1;
        pc_next = base + offset;

        // JSR/JSRR always link through R7
        dr_next = (ir[15:12] == 4'b0100) ? 3'b111 : ir[11:9];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            aluout          <= 16'h0000;
            pcout           <= 16'h0000;
            M_Data          <= 16'h0000;
            dr              <= 3'b000;
            W_Control_out   <= 2'b00;
            Mem_Control_out <= 1'b0;
            npc_out         <= 16'h0000;
        end else if (enable_execute) begin
            aluout          <= alu_next;
            pcout           <= pc_next;
            M_Data          <= vsr2;
            dr              <= dr_next;
            W_Control_out   <= W_Control_in;
            Mem_Control_out <= Mem_Control_in;
            npc_out         <= npc_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DONE marks the cycle right after any capture edge
    always_comb begin
        state_next = IDLE;
        exec_valid = 1'b0;
        case (state)
            IDLE: begin
                state_next = enable_execute ? DONE : IDLE;
            end
            DONE: begin
                exec_valid = 1'b1;
                state_next = enable_execute ? DONE : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed, table-driven bench for execute_stage plus hand sequences for
// hold, exec_valid pulse width and asynchronous reset behaviour.
module tb_execute_stage;

    logic        clock;
    logic        reset;
    logic        enable_execute;
    logic [5:0]  E_Control;
    logic [47:0] D_Data;
    logic [15:0] npc_in;
    logic [1:0]  W_Control_in;
    logic        Mem_Control_in;
    logic [15:0] aluout;
    logic [15:0] pcout;
    logic [15:0] M_Data;
    logic [2:0]  dr;
    logic [1:0]  W_Control_out;
    logic        Mem_Control_out;
    logic [15:0] npc_out;
    logic        exec_valid;

    int checks = 0;
    int errors = 0;

    execute_stage dut (
        .clock          (clock),
        .reset          (reset),
        .enable_execute (enable_execute),
        .E_Control      (E_Control),
        .D_Data         (D_Data),
        .npc_in         (npc_in),
        .W_Control_in   (W_Control_in),
        .Mem_Control_in (Mem_Control_in),
        .aluout         (aluout),
        .pcout          (pcout),
        .M_Data         (M_Data),
        .dr             (dr),
        .W_Control_out  (W_Control_out),
        .Mem_Control_out(Mem_Control_out),
        .npc_out        (npc_out),
        .exec_valid     (exec_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [5:0]  ctrl;
        logic [15:0] ir;
        logic [15:0] vsr1;
        logic [15:0] vsr2;
        logic [15:0] npc;
        logic [1:0]  wc;
        logic        mc;
        logic [15:0] exp_alu;
        logic [15:0] exp_pc;
        logic [2:0]  exp_dr;
    } vec_t;

    vec_t vectors[9];

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        E_Control      = v.ctrl;
        D_Data         = {v.ir, v.vsr1, v.vsr2};
        npc_in         = v.npc;
        W_Control_in   = v.wc;
        Mem_Control_in = v.mc;
    endtask

    task automatic checkAll(input string tag, input logic [15:0] e_alu, input logic [15:0] e_pc,
                            input logic [15:0] e_md, input logic [2:0] e_dr, input logic [1:0] e_wc,
                            input logic e_mc, input logic [15:0] e_npc, input logic e_valid);
        checkOutput({tag, ".aluout"},          aluout,                    e_alu);
        checkOutput({tag, ".pcout"},           pcout,                     e_pc);
        checkOutput({tag, ".M_Data"},          M_Data,                    e_md);
        checkOutput({tag, ".dr"},              {13'd0, dr},               {13'd0, e_dr});
        checkOutput({tag, ".W_Control_out"},   {14'd0, W_Control_out},    {14'd0, e_wc});
        checkOutput({tag, ".Mem_Control_out"}, {15'd0, Mem_Control_out},  {15'd0, e_mc});
        checkOutput({tag, ".npc_out"},         npc_out,                   e_npc);
        checkOutput({tag, ".exec_valid"},      {15'd0, exec_valid},       {15'd0, e_valid});
    endtask

    initial begin
        vec_t last;
        vec_t other;

        //                name        ctrl       ir        vsr1      vsr2      npc       wc     mc    alu       pc        dr
        vectors[0] = '{"add_imm",  6'b001000, 16'h1262, 16'h0005, 16'h0000, 16'h3000, 2'b01, 1'b0, 16'h0007, 16'h0267, 3'd1};
        vectors[1] = '{"add_wrap", 6'b000000, 16'h1000, 16'hFFFF, 16'h0001, 16'h3000, 2'b01, 1'b0, 16'h0000, 16'hFFFF, 3'd0};
        vectors[2] = '{"and",      6'b010000, 16'h5000, 16'hF0F0, 16'h0FF0, 16'h3000, 2'b01, 1'b0, 16'h00F0, 16'hF0F0, 3'd0};
        vectors[3] = '{"not",      6'b100000, 16'h967F, 16'h00FF, 16'h1234, 16'h3000, 2'b01, 1'b0, 16'hFF00, 16'hFF7E, 3'd3};
        vectors[4] = '{"br_neg",   6'b000011, 16'h0FFE, 16'h0000, 16'h0000, 16'h3001, 2'b00, 1'b0, 16'h0000, 16'h2FFF, 3'd7};
        vectors[5] = '{"jsr",      6'b000001, 16'h4805, 16'h0000, 16'h0000, 16'h3000, 2'b11, 1'b1, 16'h0000, 16'h3005, 3'd7};
        vectors[6] = '{"ldr",      6'b000100, 16'h607F, 16'h4000, 16'h0000, 16'h3000, 2'b10, 1'b0, 16'h4000, 16'h3FFF, 3'd0};
        vectors[7] = '{"bad_op",   6'b111111, 16'h1ABC, 16'h7777, 16'h0042, 16'h5555, 2'b01, 1'b1, 16'h0000, 16'h5555, 3'd5};
        vectors[8] = '{"add_neg",  6'b001000, 16'h103F, 16'h0010, 16'h0000, 16'h3000, 2'b01, 1'b0, 16'h000F, 16'h004F, 3'd0};

        reset          = 1'b1;
        enable_execute = 1'b0;
        applyStimulus(vectors[0]);
        repeat (2) @(posedge clock);
        #1;
        checkAll("reset", 16'h0, 16'h0, 16'h0, 3'd0, 2'd0, 1'b0, 16'h0, 1'b0);

        @(negedge clock);
        reset = 1'b0;

        // Back-to-back captures: enable stays high across the whole table
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            applyStimulus(vectors[i]);
            enable_execute = 1'b1;
            @(posedge clock);
            #1;
            checkAll(vectors[i].name, vectors[i].exp_alu, vectors[i].exp_pc, vectors[i].vsr2,
                     vectors[i].exp_dr, vectors[i].wc, vectors[i].mc, vectors[i].npc, 1'b1);
        end
        last = vectors[8];

        @(negedge clock);
        enable_execute = 1'b0;
        @(posedge clock);
        #1;
        checkAll("hold1", last.exp_alu, last.exp_pc, last.vsr2, last.exp_dr, last.wc, last.mc, last.npc, 1'b0);

        @(negedge clock);
        applyStimulus(vectors[3]);
        repeat (2) @(posedge clock);
        #1;
        checkAll("hold2", last.exp_alu, last.exp_pc, last.vsr2, last.exp_dr, last.wc, last.mc, last.npc, 1'b0);

        // Single enable: exec_valid for exactly one cycle
        @(negedge clock);
        applyStimulus(vectors[0]);
        enable_execute = 1'b1;
        @(negedge clock);
        enable_execute = 1'b0;
        other = vectors[0];
        checkAll("pulse_hi", other.exp_alu, other.exp_pc, other.vsr2, other.exp_dr, other.wc, other.mc, other.npc, 1'b1);
        @(negedge clock);
        checkOutput("pulse_lo.exec_valid", {15'd0, exec_valid}, 16'h0);

        // Reset between edges with enable held high clears everything at once
        applyStimulus(vectors[5]);
        enable_execute = 1'b1;
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checkAll("async_rst", 16'h0, 16'h0, 16'h0, 3'd0, 2'd0, 1'b0, 16'h0, 1'b0);
        @(posedge clock);
        #1;
        checkAll("rst_override", 16'h0, 16'h0, 16'h0, 3'd0, 2'd0, 1'b0, 16'h0, 1'b0);

        @(negedge clock);
        enable_execute = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkAll("post_rst", 16'h0, 16'h0, 16'h0, 3'd0, 2'd0, 1'b0, 16'h0, 1'b0);

        @(negedge clock);
        enable_execute = 1'b1;
        @(posedge clock);
        #1;
        other = vectors[5];
        checkAll("fresh_cap", other.exp_alu, other.exp_pc, other.vsr2, other.exp_dr, other.wc, other.mc, other.npc, 1'b1);
        @(negedge clock);
        enable_execute = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
